// File: rtl/primitive_assembler.sv
// primitive_assembler
// Collects three screen-space vertices into a triangle, computes its signed
// doubled area, derives a clamped bounding box and either culls the triangle
// (invalid vertex, back-facing/degenerate, fully off-screen) or presents it
// to the rasterizer with a valid/ready handshake.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   i_vertex_pixel[2]    vertex screen x [0], y [1] (signed)
//   i_vertex_z           vertex depth, signed Q1.ZBITS
//   i_vertex_dv          vertex valid, taken only while o_ready=1
//   i_vertex_invalid     vertex failed clip/divide (sampled with i_vertex_dv)
//   i_flush              discard partially collected triangle (COLLECT only)
//   i_ready              rasterizer can accept a triangle
//   o_ready              assembler is collecting vertices
//   o_tri_x/y/z[3]       triangle vertices in arrival order
//   o_bb_min/max[2]      clamped bounding box (x, y)
//   o_tri_dv             triangle valid, held until i_ready
//   o_cull_count         saturating count of culled triangles
module primitive_assembler #(
  parameter int DATAWIDTH     = 10,
  parameter int ZBITS         = 11,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 320,
  parameter int CULL_BACKFACE = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [DATAWIDTH-1:0] i_vertex_pixel [2],
  input  logic signed [ZBITS:0]       i_vertex_z,
  input  logic                        i_vertex_dv,
  input  logic                        i_vertex_invalid,
  input  logic                        i_flush,
  input  logic                        i_ready,
  output logic                        o_ready,
  output logic signed [DATAWIDTH-1:0] o_tri_x [3],
  output logic signed [DATAWIDTH-1:0] o_tri_y [3],
  output logic signed [ZBITS:0]       o_tri_z [3],
  output logic signed [DATAWIDTH-1:0] o_bb_min [2],
  output logic signed [DATAWIDTH-1:0] o_bb_max [2],
  output logic                        o_tri_dv,
  output logic [15:0]                 o_cull_count
);

  localparam int DW1 = DATAWIDTH + 1;
  localparam int AW  = 2 * DATAWIDTH + 3;
  localparam logic signed [DATAWIDTH-1:0] XMAX = DATAWIDTH'(SCREEN_WIDTH - 1);
  localparam logic signed [DATAWIDTH-1:0] YMAX = DATAWIDTH'(SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {COLLECT, AREA, CLASSIFY, EMIT} state_t;

  state_t                        state;
  logic [1:0]                    slot;
  logic signed [DATAWIDTH-1:0]   vx [3];
  logic signed [DATAWIDTH-1:0]   vy [3];
  logic signed [ZBITS:0]         vz [3];
  logic [2:0]                    vinv;
  logic signed [AW-1:0]          area_q;

  logic signed [DW1-1:0]         dx1, dy1, dx2, dy2;
  logic signed [AW-1:0]          px1, px2, area_next;
  logic signed [DATAWIDTH-1:0]   mnx, mxx, mny, mxy;
  logic                          cull;

  function automatic logic signed [DATAWIDTH-1:0] clamp(
    input logic signed [DATAWIDTH-1:0] v,
    input logic signed [DATAWIDTH-1:0] hi
  );
    if (v[DATAWIDTH-1]) return '0;
    else if (v > hi)    return hi;
    else                return v;
  endfunction

  always_comb o_ready = (state == COLLECT);

  // Differences are one bit wider than coordinates and products are wide
  // enough that the area never wraps.
  always_comb begin
    dx1       = DW1'(vx[1]) - DW1'(vx[0]);
    dy1       = DW1'(vy[1]) - DW1'(vy[0]);
    dx2       = DW1'(vx[2]) - DW1'(vx[0]);
    dy2       = DW1'(vy[2]) - DW1'(vy[0]);
    px1       = AW'(dx1) * AW'(dy2);
    px2       = AW'(dx2) * AW'(dy1);
    area_next = px1 - px2;
  end

  always_comb begin
    mnx = vx[0];
    mxx = vx[0];
    mny = vy[0];
    mxy = vy[0];
    for (int unsigned i = 1; i < 3; i++) begin
      if (vx[i] < mnx) mnx = vx[i];
      if (vx[i] > mxx) mxx = vx[i];
      if (vy[i] < mny) mny = vy[i];
      if (vy[i] > mxy) mxy = vy[i];
    end
  end

  // Off-screen test uses the unclamped box; A<=0 is sign bit or zero.
  always_comb begin
    cull = (|vinv)
        || ((CULL_BACKFACE != 0) && (area_q[AW-1] || (area_q == '0)))
        || mxx[DATAWIDTH-1] || mxy[DATAWIDTH-1]
        || (mnx > XMAX) || (mny > YMAX);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= COLLECT;
      slot         <= '0;
      vinv         <= '0;
      area_q       <= '0;
      o_tri_dv     <= 1'b0;
      o_cull_count <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        vx[i]      <= '0;
        vy[i]      <= '0;
        vz[i]      <= '0;
        o_tri_x[i] <= '0;
        o_tri_y[i] <= '0;
        o_tri_z[i] <= '0;
      end
      for (int unsigned i = 0; i < 2; i++) begin
        o_bb_min[i] <= '0;
        o_bb_max[i] <= '0;
      end
    end else begin
      case (state)
        COLLECT: begin
          if (i_flush) begin
            slot <= '0;
          end else if (i_vertex_dv) begin
            vx[slot]   <= i_vertex_pixel[0];
            vy[slot]   <= i_vertex_pixel[1];
            vz[slot]   <= i_vertex_z;
            vinv[slot] <= i_vertex_invalid;
            if (slot == 2'd2) begin
              slot  <= '0;
              state <= AREA;
            end else begin
              slot <= slot + 2'd1;
            end
          end
        end
        AREA: begin
          area_q <= area_next;
          state  <= CLASSIFY;
        end
        CLASSIFY: begin
          if (cull) begin
            if (o_cull_count != '1) o_cull_count <= o_cull_count + 16'd1;
            state <= COLLECT;
          end else begin
            for (int unsigned i = 0; i < 3; i++) begin
              o_tri_x[i] <= vx[i];
              o_tri_y[i] <= vy[i];
              o_tri_z[i] <= vz[i];
            end
            o_bb_min[0] <= clamp(mnx, XMAX);
            o_bb_min[1] <= clamp(mny, YMAX);
            o_bb_max[0] <= clamp(mxx, XMAX);
            o_bb_max[1] <= clamp(mxy, YMAX);
            o_tri_dv    <= 1'b1;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (i_ready) begin
            o_tri_dv <= 1'b0;
            state    <= COLLECT;
          end
        end
      endcase
    end
  end

endmodule
